// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port, the downstream valid/ready stream and the status signals.
// The design uses the slave modport; the environment driving it uses master.
interface fifo_stream_reader_if #(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [BITS-1:0]  fifo_dout;
    logic             fifo_pndng;
    logic             fifo_pop;
    logic             enable;
    logic [BITS-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] words_out;
    logic             busy;

    modport master (
        output fifo_dout, fifo_pndng, enable, out_ready,
        input  fifo_pop, out_data, out_valid, words_out, busy
    );

    modport slave (
        input  fifo_dout, fifo_pndng, enable, out_ready,
        output fifo_pop, out_data, out_valid, words_out, busy
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream.
// A two-entry buffer lets fifo_pop depend only on registered occupancy, never on out_ready.
module fifo_stream_reader #(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [BITS-1:0]  h_q, h_d;
    logic [BITS-1:0]  s_q, s_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             pop_c;
    logic             xfer_c;

    // Pop only while a slot is guaranteed free at the next edge.
    assign pop_c  = rst & bus.enable & bus.fifo_pndng & (occ_q != OCC2);
    assign xfer_c = (occ_q != OCC0) & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q   <= OCC0;
            h_q     <= '0;
            s_q     <= '0;
            words_q <= '0;
        end else begin
            occ_q   <= occ_d;
            h_q     <= h_d;
            s_q     <= s_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        occ_d   = occ_q;
        h_d     = h_q;
        s_d     = s_q;
        words_d = words_q;

        if (xfer_c) begin
            words_d = words_q + CNT_W'(1);
        end

        case (occ_q)
            OCC0: begin
                if (pop_c) begin
                    h_d   = bus.fifo_dout;
                    occ_d = OCC1;
                end
            end
            OCC1: begin
                if (pop_c && xfer_c) begin
                    h_d = bus.fifo_dout;
                end else if (xfer_c) begin
                    occ_d = OCC0;
                end else if (pop_c) begin
                    s_d   = bus.fifo_dout;
                    occ_d = OCC2;
                end
            end
            OCC2: begin
                // pop_c is low here, so only the skid entry moves forward.
                if (xfer_c) begin
                    h_d   = s_q;
                    occ_d = OCC1;
                end
            end
            default: begin
                occ_d = OCC0;
            end
        endcase
    end

    assign bus.fifo_pop  = pop_c;
    assign bus.out_valid = (occ_q != OCC0);
    assign bus.out_data  = h_q;
    assign bus.words_out = words_q;
    assign bus.busy      = (occ_q != OCC0) | pop_c;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, a monitor checks stream order.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
    localparam int unsigned BITS   = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SCNT_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.BITS(BITS), .CNT_W(CNT_W))  bus ();
    fifo_stream_reader_if #(.BITS(BITS), .CNT_W(SCNT_W)) sbus ();

    fifo_stream_reader #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow-counter twin fed with identical inputs, used for the wrap check.
    fifo_stream_reader #(.BITS(BITS), .CNT_W(SCNT_W)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    logic [BITS-1:0] mem [DEPTH];
    logic [3:0]      rd_ptr = '0;
    logic [3:0]      wr_ptr = '0;
    int              f_cnt = 0;
    int unsigned     pops_total = 0;
    logic            force_pndng = 1'b1;
    logic            pop_s = 1'b0;

    assign bus.fifo_dout   = mem[rd_ptr];
    assign bus.fifo_pndng  = (f_cnt != 0) || force_pndng;
    assign sbus.fifo_dout  = bus.fifo_dout;
    assign sbus.fifo_pndng = bus.fifo_pndng;
    assign sbus.enable     = bus.enable;
    assign sbus.out_ready  = bus.out_ready;

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] exp_q [$];
    logic [BITS-1:0] mon_exp;
    logic [BITS-1:0] prev_data = '0;
    logic            prev_stall = 1'b0;

    // FIFO model: pop decided mid-cycle, applied just after the edge.
    always @(negedge clk) pop_s = bus.fifo_pop;
    always @(posedge clk) begin
        #1;
        if (pop_s) begin
            rd_ptr     = rd_ptr + 4'd1;
            f_cnt      = f_cnt - 1;
            pops_total = pops_total + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                checks++;
                if (!bus.out_valid || bus.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=%h required valid=1 data=%h",
                             bus.out_valid, bus.out_data, prev_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: data=%h delivered with no word expected", bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.out_data !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_data: got %h expected %h", bus.out_data, mon_exp);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [BITS-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 4'd1;
        f_cnt  = f_cnt + 1;
        exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;
    int unsigned p0;
    int          pushed;

    initial begin
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;

        // Reset with pndng forced high: no pop may escape.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pop",   64'(bus.fifo_pop),   64'd0);
            chk("rst_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_data",  64'(bus.out_data),  64'd0);
            chk("rst_words", 64'(bus.words_out), 64'd0);
            chk("rst_busy",  64'(bus.busy),      64'd0);
        end
        tick();
        rst = 1'b1;
        force_pndng = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'(bus.out_valid), 64'd0);
        chk("idle_busy",  64'(bus.busy),      64'd0);
        chk("idle_pop",   64'(bus.fifo_pop),  64'd0);

        // Streaming 0..15 with ready held high.
        tick();
        for (int i = 0; i < 16; i++) push(BITS'(i));
        @(negedge clk);
        chk("lat_pop",   64'(bus.fifo_pop),  64'd1);
        chk("lat_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge clk);
            chk("str_valid", 64'(bus.out_valid), 64'd1);
            chk("str_data",  64'(bus.out_data),  64'(i));
        end
        tick();
        @(negedge clk);
        chk("str_end_valid", 64'(bus.out_valid), 64'd0);
        chk("str_end_busy",  64'(bus.busy),      64'd0);
        chk("str_words",     64'(bus.words_out), 64'd16);
        chk("str_pops",      64'(pops_total),    64'd16);
        chk("str_sb_empty",  64'(exp_q.size()),  64'd0);

        // Back-pressure: 5 words, ready low for 6 cycles.
        tick();
        bus.out_ready = 1'b0;
        p0 = pops_total;
        for (int i = 0; i < 5; i++) push(BITS'(100 + i));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1) chk("bp_data", 64'(bus.out_data), 64'd100);
            tick();
        end
        @(negedge clk);
        chk("bp_pops",  64'(pops_total - p0), 64'd2);
        chk("bp_pop0",  64'(bus.fifo_pop),    64'd0);
        chk("bp_valid", 64'(bus.out_valid),   64'd1);
        tick();
        bus.out_ready = 1'b1;
        repeat (10) tick();
        chk("bp_sb_empty", 64'(exp_q.size()),    64'd0);
        chk("bp_words",    64'(bus.words_out),   64'd21);
        chk("bp_allpops",  64'(pops_total - p0), 64'd5);

        // Enable gating after 3 pops.
        tick();
        p0 = pops_total;
        for (int i = 0; i < 8; i++) push(BITS'(200 + i));
        for (int i = 0; i < 20 && (pops_total - p0) < 3; i++) tick();
        bus.enable = 1'b0;
        @(negedge clk);
        chk("en_pops3", 64'(pops_total - p0), 64'd3);
        chk("en_pop0",  64'(bus.fifo_pop),    64'd0);
        repeat (5) tick();
        @(negedge clk);
        chk("en_drain_valid", 64'(bus.out_valid),   64'd0);
        chk("en_drain_busy",  64'(bus.busy),        64'd0);
        chk("en_hold_pops",   64'(pops_total - p0), 64'd3);
        chk("en_fifo_left",   64'(f_cnt),           64'd5);
        tick();
        bus.enable = 1'b1;
        @(negedge clk);
        chk("en_resume_pop", 64'(bus.fifo_pop), 64'd1);
        repeat (10) tick();
        chk("en_sb_empty", 64'(exp_q.size()),  64'd0);
        chk("en_words",    64'(bus.words_out), 64'd29);

        // 100 words under a fixed irregular ready pattern.
        pushed = 0;
        for (int cyc = 0; cyc < 2000 && !(pushed == 100 && exp_q.size() == 0); cyc++) begin
            tick();
            bus.out_ready = rdy_pat[cyc % 16];
            if (pushed < 100 && f_cnt < int'(DEPTH)) begin
                push(32'hA500_0000 + BITS'(pushed));
                pushed++;
            end
        end
        chk("rnd_done",  64'((pushed == 100) && (exp_q.size() == 0)), 64'd1);
        @(negedge clk);
        chk("rnd_words", 64'(bus.words_out), 64'd129);

        // Counter wrap on the narrow twin, then reset while two words are buffered.
        tick();
        bus.out_ready = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("wr_start_words",  64'(bus.words_out),  64'd0);
        chk("wr_start_swords", 64'(sbus.words_out), 64'd0);
        tick();
        for (int i = 0; i < 16; i++) push(BITS'(300 + i));
        for (int i = 0; i < 4; i++) begin
            tick();
            push(BITS'(316 + i));
        end
        for (int i = 0; i < 100 && bus.words_out != 16'd17; i++) tick();
        bus.out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("wr_words",  64'(bus.words_out),  64'd17);
        chk("wr_swords", 64'(sbus.words_out), 64'd1);
        chk("wr_pop0",   64'(bus.fifo_pop),   64'd0);
        chk("wr_valid",  64'(bus.out_valid),  64'd1);
        chk("wr_data",   64'(bus.out_data),   64'd317);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",  64'(bus.out_valid),  64'd0);
        chk("mid_rst_words",  64'(bus.words_out),  64'd0);
        chk("mid_rst_swords", 64'(sbus.words_out), 64'd0);
        chk("mid_rst_busy",   64'(bus.busy),       64'd0);
        chk("mid_rst_pop",    64'(bus.fifo_pop),   64'd0);
        exp_q.delete();
        f_cnt  = 0;
        rd_ptr = wr_ptr;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_busy",  64'(bus.busy),      64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

- Drains words from the upstream `fifo_flops` read port and presents them on a registered valid/ready stream for the next consumer.
- Hides the FIFO's pop semantics behind a 2-entry buffer, so the stream sees a standard handshake and `fifo_pop` never depends combinationally on `out_ready`.
- Sustains one word per cycle and keeps a running count of delivered words.

## Interface

Parameters:

- `BITS`, 32, data word width; matches the FIFO `bits`.
- `CNT_W`, 16, width of the delivered-word counter.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `fifo_dout`  in  BITS  FIFO head word; valid whenever `fifo_pndng`=1 (first-word-fall-through).
- `fifo_pndng`  in  1  FIFO holds at least one word.
- `fifo_pop`  out  1  removes the FIFO head at this rising edge.
- `enable`  in  1  when 0, no new pops are issued; buffered words still drain.
- `out_data`  out  BITS  stream data (registered).
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `words_out`  out  CNT_W  count of completed stream handshakes; wraps modulo 2^CNT_W.
- `busy`  out  1  buffer non-empty or `fifo_pop` asserted.

## Operation

- Internal buffer:
  - two entries, head `h` and skid `s`;
  - occupancy `occ` ∈ {0,1,2};
  - strict FIFO order.
- Pop rule: `fifo_pop = rst & enable & fifo_pndng & (occ < 2)`.
  - Combinational from registered `occ` and the inputs only.
  - Never asserted while `rst`=0.
- Load: when `fifo_pop`=1, `fifo_dout` is captured at the same edge.
- Stream handshake: a word transfers at an edge where `out_valid` & `out_ready`.
- Next occupancy: `occ_next = occ + fifo_pop − (out_valid & out_ready)`.
- Data movement on the same edge:
  - Transfer and load with `occ`=1: `h` ← `fifo_dout`.
  - Transfer with `occ`=2: `h` ← `s`; if a load also occurs, it writes `s`. A load at `occ`=2 is impossible by the pop rule.
  - Load, no transfer, `occ`=0: `h` ← `fifo_dout`.
  - Load, no transfer, `occ`=1: `s` ← `fifo_dout`.
- Outputs:
  - `out_valid = (occ != 0)`; `out_data = h`.
  - While `out_valid`=1 and `out_ready`=0, `out_data` holds constant.
  - `out_valid` never deasserts without a transfer.
- `words_out` increments by 1 on each transfer; after all-ones it wraps to 0.
- `enable` falling mid-stream: pops stop in the same cycle; words already in the buffer are still delivered.
- `fifo_pndng` falls while `occ`>0: buffered words are delivered normally.

## Timing

- Reset (`rst`=0, asynchronous):
  - `occ`=0, `out_valid`=0, `out_data`=0, `words_out`=0, `busy`=0, `fifo_pop`=0.
  - Buffer contents are discarded; FIFO contents are the FIFO's own concern.
  - Release is synchronous to the first rising edge with `rst`=1.
- Latency: FIFO non-empty, `occ`=0, `enable`=1 → `fifo_pop`=1 in cycle t → `out_valid`=1 with that word in cycle t+1.
- Throughput: with `out_ready` held at 1 and the FIFO non-empty, `fifo_pop` and a transfer occur every cycle; `occ` stays at 1.
- Back-pressure: with `out_ready`=0, at most 2 further pops complete, then `fifo_pop`=0 until a transfer occurs.
- Reset asserted mid-transfer: the in-flight word is lost. `words_out` does not count it, and the FIFO has already popped any word loaded that cycle.

## Test plan

- Reset then idle:
  - Stimulus: `rst`=0 for 3 cycles, FIFO empty.
  - Required: all outputs 0; `fifo_pop`=0 throughout, including while `fifo_pndng` is forced to 1 during reset.
- Streaming:
  - Stimulus: push 0..15 into the FIFO (depth 16, `full`=1), `enable`=1, `out_ready`=1.
  - Required: first `out_valid` one cycle after the first `fifo_pop`; data 0..15 in order on 16 consecutive cycles; `words_out`=16; `busy` falls after the last transfer.
- Back-pressure:
  - Stimulus: FIFO holds 5 words, `out_ready`=0 for 6 cycles, then 1.
  - Required: exactly 2 pops, then `fifo_pop`=0; `out_data`=word0 stable; afterwards words 0..4 delivered in order with no loss or duplication.
- Enable gating:
  - Stimulus: drop `enable` after 3 pops, with the FIFO still non-empty.
  - Required: no further pops; buffered words delivered; `out_valid`=0 once drained; pops resume the cycle `enable` returns to 1.
- Random ready:
  - Stimulus: toggle `out_ready` pseudo-randomly over 100 words.
  - Required: the scoreboard matches push order; `words_out`=100.
- Wrap and reset mid-operation:
  - Stimulus: CNT_W=4, 17 transfers, then assert `rst` while `occ`=2.
  - Required: `words_out` reads 1 before the reset, and 0 with `out_valid`=0 immediately after `rst` falls.
